// File: rtl/uart_transceiver_if.sv
// rtl/uart_transceiver_if.sv - host-side byte handshake between parallel logic and the UART
`timescale 1ns/1ps

interface uart_transceiver_if;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       tx_full;
  logic       rd_uart;
  logic       rx_empty;
  logic [7:0] r_data;

  modport master (
    output w_data, wr_uart, rd_uart,
    input  tx_full, rx_empty, r_data
  );

  modport slave (
    input  w_data, wr_uart, rd_uart,
    output tx_full, rx_empty, r_data
  );
endinterface

// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - full-duplex 8N1 UART with shared 16x tick and 4-deep FIFOs per side
// Optional build macro UART_LOOPBACK_EN feeds the receiver from tx instead of the rx pin.
`timescale 1ns/1ps

module uart_fifo #(
  parameter int AW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] w_data,
  input  logic       rd,
  output logic [7:0] r_data,
  output logic       empty,
  output logic       full
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  // count tops out at exactly 2^AW, so its MSB alone marks full
  assign full   = count[AW];
  assign empty  = (count == '0);
  assign r_data = mem[rptr];

  // a read frees a slot in the same cycle, so a full FIFO still accepts write+read
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wptr] <= w_data;
        wptr      <= wptr + AW'(1);
      end
      if (do_rd) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_transceiver #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 9600,
  parameter int DVSR    = (CLK_HZ + 8 * BAUD) / (16 * BAUD),
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  uart_transceiver_if.slave  host,
  output logic               tx,
  input  logic               rx
);
  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [CW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == CW'(DVSR - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  logic       tx_fifo_empty;
  logic       tx_pop;
  logic [7:0] tx_fifo_data;
  logic [1:0] tx_state;
  logic [3:0] tx_s;
  logic [2:0] tx_n;
  logic [7:0] tx_b;
  logic       tx_reg;

  assign tx     = tx_reg;
  assign tx_pop = (tx_state == S_IDLE) && !tx_fifo_empty;

  uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr     (host.wr_uart),
    .w_data (host.w_data),
    .rd     (tx_pop),
    .r_data (tx_fifo_data),
    .empty  (tx_fifo_empty),
    .full   (host.tx_full)
  );

  // tx is registered so it is glitch-free and snaps high on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_b     <= '0;
      tx_reg   <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (!tx_fifo_empty) begin
            tx_b     <= tx_fifo_data;
            tx_s     <= '0;
            tx_reg   <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (tx_s == 4'd15) begin
              tx_s     <= '0;
              tx_n     <= '0;
              tx_reg   <= tx_b[0];
              tx_state <= S_DATA;
            end else begin
              tx_s <= tx_s + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (tx_s == 4'd15) begin
              tx_s <= '0;
              tx_b <= {1'b0, tx_b[7:1]};
              if (tx_n == 3'd7) begin
                tx_reg   <= 1'b1;
                tx_state <= S_STOP;
              end else begin
                tx_n   <= tx_n + 3'd1;
                tx_reg <= tx_b[1];
              end
            end else begin
              tx_s <= tx_s + 4'd1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (tx_s == 4'd15) begin
              tx_s     <= '0;
              tx_state <= S_IDLE;
            end else begin
              tx_s <= tx_s + 4'd1;
            end
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  logic rx_in;

`ifdef UART_LOOPBACK_EN
  wire unused_rx_pin = rx;
  assign rx_in = tx_reg;
`else
  assign rx_in = rx;
`endif

  logic [1:0] rx_sync;
  logic       rx_s;
  logic       rx_prev;
  logic [1:0] rx_state;
  logic [3:0] rx_s_cnt;
  logic [2:0] rx_n;
  logic [7:0] rx_b;
  logic       rx_push;
  logic       rx_fifo_full_unused;

  assign rx_s    = rx_sync[1];
  assign rx_push = (rx_state == S_STOP) && tick && (rx_s_cnt == 4'd15) && rx_s;

  uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr     (rx_push),
    .w_data (rx_b),
    .rd     (host.rd_uart),
    .r_data (host.r_data),
    .empty  (host.rx_empty),
    .full   (rx_fifo_full_unused)
  );

  // IDLE waits for a true 1->0 edge so a line still low after a framing error is not a new start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_s_cnt <= '0;
      rx_n     <= '0;
      rx_b     <= '0;
    end else begin
      rx_sync <= {rx_sync[0], rx_in};
      rx_prev <= rx_s;
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_s_cnt <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_s_cnt == 4'd7) begin
              rx_s_cnt <= '0;
              rx_n     <= '0;
              rx_state <= rx_s ? S_IDLE : S_DATA;
            end else begin
              rx_s_cnt <= rx_s_cnt + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (rx_s_cnt == 4'd15) begin
              rx_s_cnt <= '0;
              rx_b     <= {rx_s, rx_b[7:1]};
              if (rx_n == 3'd7) begin
                rx_state <= S_STOP;
              end else begin
                rx_n <= rx_n + 3'd1;
              end
            end else begin
              rx_s_cnt <= rx_s_cnt + 4'd1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (rx_s_cnt == 4'd15) begin
              rx_s_cnt <= '0;
              rx_state <= S_IDLE;
            end else begin
              rx_s_cnt <= rx_s_cnt + 4'd1;
            end
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - directed self-checking bench for uart_transceiver at a shortened baud divisor
`timescale 1ns/1ps

module tb_uart_transceiver;
  localparam int DVSR  = 4;
  localparam int BIT   = 16 * DVSR;
  localparam int FRAME = 10 * BIT;
  localparam int WAIT  = 800;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx;
  logic rx;
  logic rx_drv = 1'b1;
  logic loop_mode = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [7:0] seq_bytes [11] = '{8'hA5, 8'h00, 8'hFF, 8'h3C, 8'h81, 8'h7E,
                                 8'h12, 8'hC9, 8'h55, 8'hAA, 8'h6D};
  logic [7:0] bp_bytes  [6]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  uart_transceiver_if host ();

  assign rx = loop_mode ? tx : rx_drv;

  uart_transceiver #(
    .CLK_HZ  (50_000_000),
    .BAUD    (9600),
    .DVSR    (DVSR),
    .FIFO_AW (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .host (host),
    .tx   (tx),
    .rx   (rx)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    host.w_data  = b;
    host.wr_uart = 1'b1;
    @(negedge clk);
    host.wr_uart = 1'b0;
  endtask

  task automatic read_pulse();
    host.rd_uart = 1'b1;
    @(negedge clk);
    host.rd_uart = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      idle(BIT);
    end
    rx_drv = stop;
    idle(BIT);
    rx_drv = 1'b1;
  endtask

  task automatic decode_frame(output logic [7:0] b, output logic ok);
    int n = 0;
    b  = '0;
    ok = 1'b0;
    while (tx !== 1'b0 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (tx === 1'b0) begin
      idle(BIT / 2);
      for (int i = 0; i < 8; i++) begin
        idle(BIT);
        b = {tx, b[7:1]};
      end
      idle(BIT);
      ok = tx;
    end
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] got_b;
    logic       got_ok;

    host.w_data  = '0;
    host.wr_uart = 1'b0;
    host.rd_uart = 1'b0;

    for (int k = 0; k < 2; k++) begin
      idle(100);
      check("rst_tx",       32'(tx),            32'd1);
      check("rst_tx_full",  32'(host.tx_full),  32'd0);
      check("rst_rx_empty", 32'(host.rx_empty), 32'd1);
      check("rst_r_data",   32'(host.r_data),   32'd0);
    end
    rst = 1'b1;
    idle(100);
    check("post_rst_tx",       32'(tx),            32'd1);
    check("post_rst_tx_full",  32'(host.tx_full),  32'd0);
    check("post_rst_rx_empty", 32'(host.rx_empty), 32'd1);
    check("post_rst_r_data",   32'(host.r_data),   32'd0);

    loop_mode = 1'b1;
    write_byte(8'h24);
    idle(WAIT);
    check("single_rx_empty", 32'(host.rx_empty), 32'd0);
    check("single_r_data",   32'(host.r_data),   32'h24);
    host.rd_uart = 1'b1;
    idle(2);
    host.rd_uart = 1'b0;
    check("single_drained", 32'(host.rx_empty), 32'd1);

    for (int i = 0; i < 11; i++) begin
      write_byte(seq_bytes[i]);
      idle(WAIT);
      check("seq_rx_empty", 32'(host.rx_empty), 32'd0);
      check("seq_r_data",   32'(host.r_data),   32'(seq_bytes[i]));
      read_pulse();
      check("seq_popped",   32'(host.rx_empty), 32'd1);
    end

    for (int i = 0; i < 6; i++) begin
      host.w_data  = bp_bytes[i];
      host.wr_uart = 1'b1;
      @(negedge clk);
      if (i == 3) check("bp_not_full_4th", 32'(host.tx_full), 32'd0);
      if (i == 4) check("bp_full_5th",     32'(host.tx_full), 32'd1);
    end
    host.wr_uart = 1'b0;
    check("bp_still_full", 32'(host.tx_full), 32'd1);
    for (int i = 0; i < 5; i++) begin
      decode_frame(got_b, got_ok);
      check("bp_frame_ok",   32'(got_ok), 32'd1);
      check("bp_frame_byte", 32'(got_b),  32'(bp_bytes[i]));
    end
    decode_frame(got_b, got_ok);
    check("bp_no_6th_frame", 32'(got_ok), 32'd0);
    check("bp_tx_full_clr",  32'(host.tx_full), 32'd0);

    for (int i = 0; i < 4; i++) begin
      check("ovr_rx_empty", 32'(host.rx_empty), 32'd0);
      check("ovr_r_data",   32'(host.r_data),   32'(bp_bytes[i]));
      read_pulse();
    end
    check("ovr_5th_dropped", 32'(host.rx_empty), 32'd1);

    loop_mode = 1'b0;
    rx_drv = 1'b0;
    idle(BIT * 3 / 10);
    rx_drv = 1'b1;
    idle(FRAME + 200);
    check("glitch_ignored", 32'(host.rx_empty), 32'd1);

    send_frame(8'h55, 1'b0);
    idle(200);
    check("frame_err_drop", 32'(host.rx_empty), 32'd1);
    send_frame(8'hA3, 1'b1);
    idle(100);
    check("after_ferr_empty", 32'(host.rx_empty), 32'd0);
    check("after_ferr_data",  32'(host.r_data),   32'hA3);
    read_pulse();

    loop_mode = 1'b1;
    write_byte(8'h00);
    idle(3 * BIT);
    check("midframe_tx_low", 32'(tx), 32'd0);
    #3;
    rst = 1'b0;
    #1;
    check("midframe_async_tx", 32'(tx), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    idle(2 * FRAME);
    check("midframe_rx_empty", 32'(host.rx_empty), 32'd1);
    check("midframe_tx_idle",  32'(tx),            32'd1);
    check("midframe_tx_full",  32'(host.tx_full),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
